ncl_issue_arbiter: RTL and testbench
====================================

NCL_ISSUE_ARBITER -- requirements
Module: ncl_issue_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum clk cycles allowed per handshake phase before an error is raised.
REQ-002 Parameter CNT_W, default 16: width of issue_count.
REQ-003 clk  input  1  single clock for all state; all flops rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 req_a  input  1  requester A (fetch) has an instruction pending; held until gnt_a.
REQ-006 instr_a  input  8  requester A single-rail instruction; valid while req_a=1.
REQ-007 gnt_a  output  1  one-cycle pulse: instr_a captured.
REQ-008 req_b, instr_b[7:0], gnt_b: same as REQ-005..007 for requester B (debug).
REQ-009 instruction  output  16  dual-rail word to the NCL controller stage; bit 2k+1 = true rail of bit k, bit 2k = false rail.
REQ-010 ack_pos  input  1  asynchronous acknowledge from the NCL stage (1 = DATA accepted / request-for-NULL, 0 = NULL accepted / request-for-DATA).
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 timeout_err  output  1  sticky error flag.
REQ-013 clear_err  input  1  clears timeout_err and leaves ERR.
REQ-014 issue_count  output  CNT_W  count of completed four-phase transactions.

Function
REQ-015 ack_pos SHALL pass through a 2-flop synchronizer (ack_s) before use; ack_s updates 2 cycles after ack_pos changes.
REQ-016 States: IDLE, DATA, NULL, ERR; all outputs registered.
REQ-017 IDLE: instruction = 16'h0000 (NULL); if ack_s=0 and any req is high, grant one requester that cycle (gnt pulse), capture its instr, and go to DATA.
REQ-018 IDLE with ack_s=1: no grant; remain in IDLE (stage not yet ready).
REQ-019 Arbitration: round-robin; on simultaneous req_a and req_b, grant the requester not granted last; after reset, A wins the first tie.
REQ-020 DATA: instruction = dual-rail encoding of the captured byte (exactly one rail high per bit); on ack_s=1 go to NULL.
REQ-021 NULL: instruction = 16'h0000; on ack_s=0 increment issue_count (modulo 2^CNT_W, wraps to 0) and go to IDLE.
REQ-022 The earliest next grant SHALL occur in the cycle after the return to IDLE; gnt_a/gnt_b SHALL never both be high.
REQ-023 The instruction output SHALL only move DATA->NULL->DATA, never DATA->DATA, and SHALL never have both rails of any bit high.
REQ-024 Phase counter: reset to 0 on entry to DATA or NULL; increments each cycle in that state; when it reaches TIMEOUT_CYCLES without the awaited ack_s edge -> ERR, with timeout_err=1.
REQ-025 ERR: instruction = 16'h0000; no grants; issue_count not incremented; on clear_err=1 and ack_s=0 -> IDLE and timeout_err=0; clear_err with ack_s=1 clears nothing and the block stays in ERR.
REQ-026 clear_err outside ERR: no effect.
REQ-027 ack_s=1 arriving in the same cycle as the timeout limit: the ack wins (normal transition, no error).

Reset
REQ-028 rst=1 (synchronous, any state, including mid-handshake): state=IDLE, instruction=16'h0000, gnt_a=gnt_b=0, busy=0, timeout_err=0, issue_count=0, synchronizer flops=0, round-robin pointer=B-last (A priority), phase counter=0.
REQ-029 A request held through reset SHALL be granted no earlier than the first cycle after rst falls, and only once ack_s=0.

Verification
REQ-030 req_a=1, instr_a=8'hA5, ack_pos model responds in 3 cycles -> gnt_a pulse; instruction=16'h9966; after ack=1 instruction=16'h0000; after ack=0, issue_count=1.
REQ-031 req_a=req_b=1 held for 3 transactions -> grant order A, B, A; gnt_a and gnt_b never high in the same cycle.
REQ-032 ack_pos stuck at 0 in DATA, TIMEOUT_CYCLES=8 -> ERR 8 cycles after DATA entry; timeout_err=1; instruction=0; clear_err with ack=0 -> IDLE, timeout_err=0.
REQ-033 rst asserted in NULL with issue_count=5 -> next cycle IDLE, issue_count=0, instruction=0; a pending req_b is granted after rst falls.
REQ-034 issue_count=16'hFFFF, one transaction completes -> issue_count=0.
REQ-035 ack_pos=1 at reset release with req_a=1 -> no gnt_a until ack_s=0; a checker confirms no invalid dual-rail (both rails high) on any cycle across all tests.

Source files
------------

// File: rtl/ncl_issue_arbiter.sv
// Round-robin issue arbiter feeding a four-phase NCL stage: grants one of two
// single-rail requesters and drives the captured byte out as a dual-rail DATA/NULL word.
module ncl_issue_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [7:0]       instr_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [7:0]       instr_b,
  output logic             gnt_b,
  output logic [15:0]      instruction,
  input  logic             ack_pos,
  output logic             busy,
  output logic             timeout_err,
  input  logic             clear_err,
  output logic [CNT_W-1:0] issue_count
);

  localparam int unsigned PH_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PH_W-1:0] PH_LIMIT = PH_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_NULL,
    S_ERR
  } state_t;

  state_t           r_state,       w_state_nxt;
  logic [PH_W-1:0]  r_phase,       w_phase_nxt;
  logic [15:0]      r_instruction, w_instruction_nxt;
  logic [CNT_W-1:0] r_issue_count, w_issue_count_nxt;
  logic             r_gnt_a,       w_gnt_a_nxt;
  logic             r_gnt_b,       w_gnt_b_nxt;
  logic             r_busy,        w_busy_nxt;
  logic             r_timeout_err, w_timeout_err_nxt;
  logic             r_last_b,      w_last_b_nxt;
  logic             r_ack_meta,    r_ack_s;
  logic             w_pick_b;

  function automatic logic [15:0] dual_rail(input logic [7:0] b);
    logic [15:0] d;
    for (int k = 0; k < 8; k++) begin
      d[2*k+1] = b[k];
      d[2*k]   = ~b[k];
    end
    return d;
  endfunction

  // B wins when it is the only requester, or on a tie when A was granted last.
  assign w_pick_b = req_b && (!req_a || !r_last_b);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt       = r_state;
    w_phase_nxt       = r_phase;
    w_instruction_nxt = r_instruction;
    w_issue_count_nxt = r_issue_count;
    w_gnt_a_nxt       = 1'b0;
    w_gnt_b_nxt       = 1'b0;
    w_timeout_err_nxt = r_timeout_err;
    w_last_b_nxt      = r_last_b;

    unique case (r_state)
      S_IDLE: begin
        if (!r_ack_s && (req_a || req_b)) begin
          w_state_nxt = S_DATA;
          w_phase_nxt = '0;
          if (w_pick_b) begin
            w_gnt_b_nxt       = 1'b1;
            w_last_b_nxt      = 1'b1;
            w_instruction_nxt = dual_rail(instr_b);
          end else begin
            w_gnt_a_nxt       = 1'b1;
            w_last_b_nxt      = 1'b0;
            w_instruction_nxt = dual_rail(instr_a);
          end
        end
      end
      S_DATA: begin
        // The awaited ack edge is tested before the limit so a coincident ack wins.
        if (r_ack_s) begin
          w_state_nxt       = S_NULL;
          w_phase_nxt       = '0;
          w_instruction_nxt = '0;
        end else if (r_phase == PH_LIMIT) begin
          w_state_nxt       = S_ERR;
          w_timeout_err_nxt = 1'b1;
          w_instruction_nxt = '0;
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      S_NULL: begin
        if (!r_ack_s) begin
          w_state_nxt       = S_IDLE;
          w_issue_count_nxt = r_issue_count + 1'b1;
        end else if (r_phase == PH_LIMIT) begin
          w_state_nxt       = S_ERR;
          w_timeout_err_nxt = 1'b1;
        end else begin
          w_phase_nxt = r_phase + 1'b1;
        end
      end
      S_ERR: begin
        if (clear_err && !r_ack_s) begin
          w_state_nxt       = S_IDLE;
          w_timeout_err_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      r_state       <= S_IDLE;
      r_phase       <= '0;
      r_instruction <= '0;
      r_issue_count <= '0;
      r_gnt_a       <= 1'b0;
      r_gnt_b       <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_last_b      <= 1'b1;
      r_ack_meta    <= 1'b0;
      r_ack_s       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_phase       <= w_phase_nxt;
      r_instruction <= w_instruction_nxt;
      r_issue_count <= w_issue_count_nxt;
      r_gnt_a       <= w_gnt_a_nxt;
      r_gnt_b       <= w_gnt_b_nxt;
      r_busy        <= w_busy_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_last_b      <= w_last_b_nxt;
      r_ack_meta    <= ack_pos;
      r_ack_s       <= r_ack_meta;
    end
  end

  assign gnt_a       = r_gnt_a;
  assign gnt_b       = r_gnt_b;
  assign instruction = r_instruction;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_ncl_issue_arbiter.sv
// Directed bench for ncl_issue_arbiter: grant scoreboard, NCL ack responder model,
// and per-cycle dual-rail / grant-exclusivity invariants.
module tb_ncl_issue_arbiter;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b;
  logic [7:0]       instr_a, instr_b;
  logic             gnt_a, gnt_b;
  logic [15:0]      instruction;
  logic             ack_pos;
  logic             busy, timeout_err, clear_err;
  logic [CNT_W-1:0] issue_count;

  logic             ack_auto, ack_manual, ack_model;
  logic [1:0]       ack_dly;
  logic [15:0]      prev_instr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        is_b;
    logic [15:0] instr;
  } exp_t;
  exp_t sb_q[$];

  ncl_issue_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .instr_a(instr_a), .gnt_a(gnt_a),
    .req_b(req_b), .instr_b(instr_b), .gnt_b(gnt_b),
    .instruction(instruction), .ack_pos(ack_pos),
    .busy(busy), .timeout_err(timeout_err), .clear_err(clear_err),
    .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  assign ack_pos = ack_auto ? ack_model : ack_manual;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [7:0] b);
    logic [15:0] e = '0;
    for (int k = 0; k < 8; k++) e |= (b[k] ? 16'h2 : 16'h1) << (2 * k);
    return e;
  endfunction

  // NCL stage model: follows the DATA/NULL wavefront after three cycles.
  always @(posedge clk) begin
    if (rst || !ack_auto) begin
      ack_model <= 1'b0;
      ack_dly   <= '0;
    end else if ((instruction != 16'h0) != ack_model) begin
      if (ack_dly == 2'd2) begin
        ack_model <= (instruction != 16'h0);
        ack_dly   <= '0;
      end else begin
        ack_dly <= ack_dly + 2'd1;
      end
    end else begin
      ack_dly <= '0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    check("gnt_exclusive", {31'b0, gnt_a & gnt_b}, 32'h0);
    check("dual_rail_valid", {16'b0, instruction & (instruction >> 1) & 16'h5555}, 32'h0);
    if (instruction != 16'h0 && prev_instr != 16'h0)
      check("no_data_to_data", {16'b0, instruction}, {16'b0, prev_instr});
    prev_instr = instruction;
    if (gnt_a || gnt_b) begin
      if (sb_q.size() == 0) begin
        check("unexpected_gnt", {30'b0, gnt_b, gnt_a}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("gnt_who_b", {31'b0, gnt_b}, {31'b0, e.is_b});
        check("gnt_instr", {16'b0, instruction}, {16'b0, e.instr});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_gnt(input logic is_b, input logic [7:0] b);
    sb_q.push_back('{is_b: is_b, instr: enc(b)});
  endtask

  task automatic wait_gnt(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(gnt_a || gnt_b) && n < 60);
    check(tag, {31'b0, gnt_a | gnt_b}, 32'h1);
  endtask

  task automatic wait_null(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(busy && instruction == 16'h0) && n < 60);
    check(tag, {31'b0, busy && instruction == 16'h0}, 32'h1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 80);
    check(tag, {31'b0, busy}, 32'h0);
  endtask

  task automatic do_txn(input logic is_b, input logic [7:0] b);
    expect_gnt(is_b, b);
    if (is_b) begin instr_b = b; req_b = 1'b1; end
    else      begin instr_a = b; req_a = 1'b1; end
    wait_gnt("txn_gnt");
    req_a = 1'b0;
    req_b = 1'b0;
    wait_idle("txn_idle");
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; instr_a = '0; instr_b = '0;
    clear_err = 1'b0; ack_auto = 1'b1; ack_manual = 1'b0; prev_instr = '0;
    step(3);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_instr", {16'b0, instruction}, 32'h0);
    check("rst_gnt", {30'b0, gnt_a, gnt_b}, 32'h0);
    check("rst_err", {31'b0, timeout_err}, 32'h0);
    check("rst_count", {28'b0, issue_count}, 32'h0);
    rst = 1'b0;

    // Simultaneous requests held across three transactions: A, B, A.
    instr_a = 8'h11; instr_b = 8'h22;
    expect_gnt(1'b0, 8'h11); expect_gnt(1'b1, 8'h22); expect_gnt(1'b0, 8'h11);
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 0; i < 3; i++) wait_gnt("tie_gnt");
    req_a = 1'b0; req_b = 1'b0;
    wait_idle("tie_idle");
    check("tie_count", {28'b0, issue_count}, 32'h3);

    // Single A transaction with 8'hA5, watching each phase.
    expect_gnt(1'b0, 8'hA5);
    instr_a = 8'hA5; req_a = 1'b1;
    wait_gnt("a5_gnt");
    req_a = 1'b0;
    check("a5_encoding", {16'b0, instruction}, 32'h9966);
    wait_null("a5_null");
    check("a5_null_count", {28'b0, issue_count}, 32'h3);
    wait_idle("a5_idle");
    check("a5_count", {28'b0, issue_count}, 32'h4);

    do_txn(1'b1, 8'h3C);
    check("b_count", {28'b0, issue_count}, 32'h5);

    clear_err = 1'b1; step(1); clear_err = 1'b0;
    check("clr_idle_err", {31'b0, timeout_err}, 32'h0);
    check("clr_idle_busy", {31'b0, busy}, 32'h0);

    // ack stuck low in DATA: ERR eight cycles after entry.
    ack_auto = 1'b0; ack_manual = 1'b0;
    expect_gnt(1'b0, 8'h5A);
    instr_a = 8'h5A; req_a = 1'b1;
    wait_gnt("to_gnt");
    req_a = 1'b0;
    step(7);
    check("to_not_early", {31'b0, timeout_err}, 32'h0);
    step(1);
    check("to_err", {31'b0, timeout_err}, 32'h1);
    check("to_instr", {16'b0, instruction}, 32'h0);
    check("to_busy", {31'b0, busy}, 32'h1);
    ack_manual = 1'b1; step(3);
    clear_err = 1'b1; step(1); clear_err = 1'b0;
    check("to_clr_ack1_err", {31'b0, timeout_err}, 32'h1);
    check("to_clr_ack1_busy", {31'b0, busy}, 32'h1);
    ack_manual = 1'b0; step(3);
    clear_err = 1'b1; step(1); clear_err = 1'b0;
    check("to_clr_err", {31'b0, timeout_err}, 32'h0);
    check("to_clr_busy", {31'b0, busy}, 32'h0);
    check("to_count", {28'b0, issue_count}, 32'h5);
    ack_auto = 1'b1;

    // Reset in NULL with a pending B request.
    expect_gnt(1'b0, 8'h0F);
    instr_a = 8'h0F; req_a = 1'b1;
    wait_gnt("rn_gnt_a");
    req_a = 1'b0;
    wait_null("rn_null");
    check("rn_pre_count", {28'b0, issue_count}, 32'h5);
    instr_b = 8'hC3; req_b = 1'b1; rst = 1'b1;
    expect_gnt(1'b1, 8'hC3);
    step(1);
    check("rn_busy", {31'b0, busy}, 32'h0);
    check("rn_count", {28'b0, issue_count}, 32'h0);
    check("rn_instr", {16'b0, instruction}, 32'h0);
    check("rn_gnt", {30'b0, gnt_a, gnt_b}, 32'h0);
    step(1);
    rst = 1'b0;
    wait_gnt("rn_gnt_b");
    req_b = 1'b0;
    wait_idle("rn_idle");
    check("rn_post_count", {28'b0, issue_count}, 32'h1);

    // Counter wrap at 2^CNT_W.
    for (int i = 0; i < 14; i++) do_txn(i[0], 8'($urandom_range(0, 255)));
    check("wrap_max", {28'b0, issue_count}, 32'hF);
    do_txn(1'b0, 8'hFF);
    check("wrap_zero", {28'b0, issue_count}, 32'h0);

    // Stage not ready (ack_s high): requests wait until ack returns low.
    ack_auto = 1'b0; ack_manual = 1'b1; rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    instr_a = 8'h96; req_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("nr_no_gnt", {30'b0, gnt_a, gnt_b}, 32'h0);
    end
    check("nr_busy", {31'b0, busy}, 32'h0);
    expect_gnt(1'b0, 8'h96);
    ack_manual = 1'b0; ack_auto = 1'b1;
    wait_gnt("nr_gnt");
    req_a = 1'b0;
    wait_idle("nr_idle");
    check("nr_count", {28'b0, issue_count}, 32'h1);

    step(2);
    check("sb_drained", sb_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
